// File: rtl/quadrilatero_multi_sa_issue_controller.sv
// quadrilatero_multi_sa_issue_controller
//   In-order issue queue that feeds N_SA systolic-array write-load stages.
//   Dispatched instructions are held in a circular buffer. The head entry is
//   issued to one ready array, and the array is chosen round-robin.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   flush_i                 discard all queued entries
//   dispatch_i              push request, carries dispatched_instr_i
//   issue_queue_full_o      almost-full back-pressure (count >= N_SLOTS-AF_MARGIN)
//   usage_o                 current occupancy
//   wl_ready_i[N_SA]        per-array WL-ready
//   start_o[N_SA]           one-hot issue strobe, qualifies issued_instr_o
//   issued_instr_o          head instruction (0 when empty)
//   overflow_o              sticky, set by a push into a full queue
//
// Optional build macro QUADRILATERO_ISSUE_PERF_EN adds saturating counters
//   perf_issued_o[N_SA] (issues per array) and perf_stall_o (cycles stalled
//   with a non-empty queue and no array ready).
module quadrilatero_multi_sa_issue_controller #(
    parameter int N_SLOTS     = 4,
    parameter int N_SA        = 2,
    parameter int INSTR_WIDTH = 64,
    parameter int AF_MARGIN   = 1,
    parameter int CNT_W       = $clog2(N_SLOTS + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   dispatch_i,
    input  logic [INSTR_WIDTH-1:0] dispatched_instr_i,
    output logic                   issue_queue_full_o,
    output logic [CNT_W-1:0]       usage_o,
    input  logic [N_SA-1:0]        wl_ready_i,
    output logic [N_SA-1:0]        start_o,
    output logic [INSTR_WIDTH-1:0] issued_instr_o,
`ifdef QUADRILATERO_ISSUE_PERF_EN
    output logic [N_SA-1:0][31:0]  perf_issued_o,
    output logic [31:0]            perf_stall_o,
`endif
    output logic                   overflow_o
);
    localparam int PTR_W = $clog2(N_SLOTS);
    localparam int RR_W  = (N_SA > 1) ? $clog2(N_SA) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N_SLOTS);
    localparam logic [CNT_W-1:0] AF_TH    = CNT_W'(N_SLOTS - AF_MARGIN);

    logic [INSTR_WIDTH-1:0] r_mem [N_SLOTS];
    logic [PTR_W-1:0]       r_head, r_tail;
    logic [CNT_W-1:0]       r_count;
    logic [RR_W-1:0]        r_rr;
    logic                   r_ovf;

    logic [N_SA-1:0]        w_grant;
    logic [RR_W-1:0]        w_rr_next;
    logic                   w_found;
    logic                   w_push, w_pop, w_empty;
    int                     w_idx;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(N_SLOTS - 1)) ? '0 : p + 1'b1;
    endfunction

    // Round-robin search: the first ready array at or above r_rr, with wrap.
    always_comb begin
        w_grant   = '0;
        w_rr_next = r_rr;
        w_found   = 1'b0;
        w_idx     = 0;
        for (int i = 0; i < N_SA; i++) begin
            w_idx = (int'(r_rr) + i) % N_SA;
            if (!w_found && wl_ready_i[w_idx]) begin
                w_grant[w_idx] = 1'b1;
                w_rr_next      = RR_W'((w_idx + 1) % N_SA);
                w_found        = 1'b1;
            end
        end
    end

    assign w_empty = (r_count == '0);
    // A flush empties the queue, so a concurrent dispatch always fits.
    assign w_push  = ~rst_i & dispatch_i & (flush_i | (r_count != FULL_CNT));
    assign w_pop   = ~rst_i & ~flush_i & ~w_empty & w_found;

    assign start_o            = w_pop ? w_grant : '0;
    assign issued_instr_o     = (~rst_i & ~w_empty) ? r_mem[r_head] : '0;
    assign usage_o            = rst_i ? '0 : r_count;
    assign issue_queue_full_o = ~rst_i & (r_count >= AF_TH);
    assign overflow_o         = ~rst_i & r_ovf;

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_tail] <= dispatched_instr_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_rr    <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (dispatch_i && !w_push) r_ovf <= 1'b1;
            if (w_push) r_tail <= ptr_inc(r_tail);
            if (flush_i) begin
                r_head  <= r_tail;
                r_count <= w_push ? CNT_W'(1) : '0;
            end else begin
                if (w_pop) r_head <= ptr_inc(r_head);
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            end
            if (w_pop) r_rr <= w_rr_next;
        end
    end

`ifdef QUADRILATERO_ISSUE_PERF_EN
    logic [N_SA-1:0][31:0] r_perf_issued;
    logic [31:0]           r_perf_stall;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_perf_issued <= '0;
            r_perf_stall  <= '0;
        end else begin
            for (int k = 0; k < N_SA; k++)
                if (start_o[k] && r_perf_issued[k] != 32'hFFFF_FFFF)
                    r_perf_issued[k] <= r_perf_issued[k] + 32'd1;
            if (!w_empty && wl_ready_i == '0 && r_perf_stall != 32'hFFFF_FFFF)
                r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_issued_o = rst_i ? '0 : r_perf_issued;
    assign perf_stall_o  = rst_i ? '0 : r_perf_stall;
`endif

endmodule

// File: tb/tb_quadrilatero_multi_sa_issue_controller.sv
// Scoreboard bench for quadrilatero_multi_sa_issue_controller (N_SLOTS=4,
// N_SA=2, AF_MARGIN=1). Accepted pushes are queued. Each issue pops the
// queue and compares. The expected grant, occupancy and flags come from a
// small reference model that is kept next to the queue.
module tb_quadrilatero_multi_sa_issue_controller;
    localparam int NS = 4, NA = 2, W = 64, AFM = 1, CW = $clog2(NS + 1);

    logic          clk = 1'b0;
    logic          rst, flush, dispatch;
    logic [W-1:0]  instr;
    logic          full;
    logic [CW-1:0] usage;
    logic [NA-1:0] wl_ready, start;
    logic [W-1:0]  issued;
    logic          ovf;

    always #5 clk = ~clk;

    quadrilatero_multi_sa_issue_controller #(
        .N_SLOTS(NS), .N_SA(NA), .INSTR_WIDTH(W), .AF_MARGIN(AFM)
    ) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .dispatch_i(dispatch),
        .dispatched_instr_i(instr), .issue_queue_full_o(full), .usage_o(usage),
        .wl_ready_i(wl_ready), .start_o(start), .issued_instr_o(issued),
        .overflow_o(ovf)
    );

    logic [W-1:0] sb[$];
    int           m_rr  = 0;
    logic         m_ovf = 1'b0;
    int unsigned  n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Check the outputs at the falling edge, then advance the model across the rising edge.
    task automatic step();
        logic [NA-1:0] eg;
        int            gi;
        bit            pop, push_ok;
        @(negedge clk);
        eg = '0;
        gi = -1;
        if (!rst && !flush && sb.size() != 0)
            for (int i = 0; i < NA; i++)
                if (gi < 0 && wl_ready[(m_rr + i) % NA]) gi = (m_rr + i) % NA;
        if (gi >= 0) eg[gi] = 1'b1;
        pop = (gi >= 0);
        chk("start", W'(start), W'(eg));
        chk("usage", W'(usage), rst ? '0 : W'(sb.size()));
        chk("full", W'(full), W'(!rst && sb.size() >= NS - AFM));
        chk("overflow", W'(ovf), W'(!rst && m_ovf));
        chk("instr", issued, (rst || sb.size() == 0) ? '0 : sb[0]);
        @(posedge clk);
        if (rst) begin
            sb.delete();
            m_rr  = 0;
            m_ovf = 1'b0;
        end else begin
            push_ok = dispatch && (flush || sb.size() < NS);
            if (dispatch && !push_ok) m_ovf = 1'b1;
            if (flush) sb.delete();
            else if (pop) begin
                void'(sb.pop_front());
                m_rr = (gi + 1) % NA;
            end
            if (push_ok) sb.push_back(instr);
        end
        #1;
    endtask

    task automatic push(input logic [W-1:0] v);
        dispatch = 1'b1; instr = v; step(); dispatch = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; dispatch = 1'b0; instr = '0; wl_ready = '0;
        step(); step();
        rst = 1'b0;
        step();
        // Fill with no array ready.
        push(64'hA); push(64'hB); push(64'hC);
        chk("full_after_3", W'(full), W'(1));
        push(64'hD);
        // Push into a full queue: the entry is dropped and overflow sticks.
        push(64'hE);
        step();
        chk("ovf_sticky", W'(ovf), W'(1));
        // Drain with both arrays ready: the grants alternate 01,10,01,10.
        wl_ready = 2'b11;
        repeat (5) step();
        // Only array 1 ready: it is granted regardless of the pointer.
        wl_ready = 2'b00;
        push(64'h11); push(64'h12);
        wl_ready = 2'b10;
        repeat (3) step();
        // No fall-through: an entry pushed into an empty queue issues one cycle later.
        wl_ready = 2'b11;
        push(64'h5A);
        chk("issue_next", W'(start != 0), W'(1));
        chk("issue_x", issued, 64'h5A);
        step();
        // Flush together with a dispatch while arrays are ready.
        wl_ready = 2'b00;
        push(64'h21); push(64'h22); push(64'h23);
        wl_ready = 2'b11; flush = 1'b1; dispatch = 1'b1; instr = 64'h77;
        step();
        flush = 1'b0; dispatch = 1'b0; wl_ready = 2'b00;
        step();
        chk("flush_usage", W'(usage), W'(1));
        chk("flush_head", issued, 64'h77);
        wl_ready = 2'b01;
        step();
        // Reset mid-stream with two entries queued and overflow set.
        wl_ready = 2'b00;
        push(64'h31); push(64'h32);
        rst = 1'b1; dispatch = 1'b1; flush = 1'b1; instr = 64'h99;
        step();
        rst = 1'b0; dispatch = 1'b0; flush = 1'b0;
        step();
        chk("rst_usage", W'(usage), '0);
        chk("rst_ovf", W'(ovf), '0);
        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            dispatch = ($urandom_range(0, 99) < 60);
            instr    = {$urandom, $urandom};
            wl_ready = NA'($urandom);
            flush    = ($urandom_range(0, 99) < 4);
            step();
        end
        dispatch = 1'b0; flush = 1'b0; wl_ready = '1;
        repeat (NS + 1) step();
        chk("drained", W'(usage), '0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
